// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared FSM state encoding and default sizing for the stall controller
package pipeline_stall_ctrl_pkg;
  typedef enum logic [1:0] {INIT, RUN, WAIT, HALT} state_e;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter (clk, rst_n, inc, clear -> cnt), sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/branch/dmem-wait -> stage we/flush, timeout halt, stall/flush counters
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_if_we,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic freeze, run, init, br, lu;
  assign freeze = dmem_req & ~dmem_ready;
  assign run = (state_q == RUN) || (state_q == WAIT);
  assign init = state_q == INIT;
  assign br = run & ~freeze & ex_branch_taken;
  assign lu = run & ~freeze & ~ex_branch_taken & ~hz_if_we;
  always_comb begin
    state_d = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        state_d = freeze ? WAIT : RUN;
        wait_cnt_d = freeze ? WW'(1) : '0;
      end
      WAIT: begin
        state_d = !freeze ? RUN : (wait_cnt_q == WW'(MEM_TIMEOUT - 1)) ? HALT : WAIT;
        wait_cnt_d = freeze ? wait_cnt_q + 1'b1 : '0;
      end
      default: state_d = HALT;
    endcase
    pc_we = run & ~freeze & ~lu;
    if_id_we = run & ~freeze & ~lu;
    id_ex_we = run & ~freeze;
    ex_mem_we = run & ~freeze;
    mem_wb_we = run;
    if_id_flush = init | br;
    id_ex_flush = init | br | lu;
    mem_wb_flush = init | (run & freeze);
    halted = state_q == HALT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(run & ~pc_we), .clear(init), .cnt(stall_cnt)
  );
  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(br), .clear(init), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed + random stimulus against a cycle-level behavioural model
module tb_pipeline_stall_ctrl;
  localparam int MT = 4;
  localparam int CW = 3;
  localparam int SAT = 7;
  logic clk = 0, rst_n = 0, hz_if_we = 1, ex_branch_taken = 0, dmem_req = 0, dmem_ready = 0;
  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, mem_wb_flush, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
  bit m_init = 1, m_halt = 0;
  int m_frozen = 0, m_stall = 0, m_flush = 0;
  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hz_if_we(hz_if_we), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  wire [7:0] dut_out = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, mem_wb_flush};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // order: pc_we if_id_we if_id_flush id_ex_we id_ex_flush ex_mem_we mem_wb_we mem_wb_flush
  function automatic logic [7:0] expect_out();
    if (!rst_n || m_init) return 8'b0010_1001;
    if (m_halt) return 8'b0000_0000;
    if (dmem_req && !dmem_ready) return 8'b0000_0011;
    if (ex_branch_taken) return 8'b1111_1110;
    if (!hz_if_we) return 8'b0001_1110;
    return 8'b1101_0110;
  endfunction
  task automatic model_reset();
    m_init = 1; m_halt = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
  endtask
  task automatic model_clock();
    logic [7:0] e;
    bit fz;
    if (!rst_n) return;
    e = expect_out();
    fz = dmem_req && !dmem_ready;
    if (m_init) m_init = 0;
    else if (!m_halt) begin
      if (!e[7] && m_stall < SAT) m_stall++;
      if (!fz && ex_branch_taken && m_flush < SAT) m_flush++;
      if (fz) begin
        m_frozen++;
        if (m_frozen == MT) m_halt = 1;
      end else m_frozen = 0;
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_ctl"}, 32'(dut_out), 32'(expect_out()));
    check({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    check({tag, "_halt"}, 32'(halted), 32'(m_halt));
  endtask
  task automatic drive(input bit rn, input bit hz, input bit br, input bit req, input bit rdy, input string tag);
    @(negedge clk);
    rst_n = rn; hz_if_we = hz; ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    if (!rn) model_reset();
    #1;
    check_all(tag);
    model_clock();
  endtask
  initial begin
    drive(0, 1, 0, 0, 0, "rst");
    drive(1, 1, 0, 0, 0, "init");
    drive(1, 1, 0, 0, 0, "run");
    check("run_pc_we", 32'(pc_we), 1);
    drive(1, 0, 0, 0, 0, "lu");
    drive(1, 1, 0, 0, 0, "lu_after");
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    drive(1, 0, 1, 0, 0, "brhz");
    check("brhz_pc_we", 32'(pc_we), 1);
    drive(1, 1, 0, 0, 0, "brhz_after");
    check("brhz_flush_cnt", 32'(flush_cnt), 1);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0, "memwait");
    check("memwait_wb_flush", 32'(mem_wb_flush), 1);
    drive(1, 1, 0, 1, 1, "memdone");
    drive(1, 1, 0, 0, 0, "memidle");
    check("memwait_stall_cnt", 32'(stall_cnt), 4);
    drive(0, 1, 0, 0, 0, "to_rst");
    drive(1, 1, 0, 0, 0, "to_init");
    for (int i = 0; i < MT; i++) drive(1, 1, 0, 1, 0, "to_frz");
    drive(1, 1, 1, 0, 0, "to_halt");
    check("to_halted", 32'(halted), 1);
    check("to_all_off", 32'(dut_out), 0);
    drive(0, 1, 0, 0, 0, "sat_rst");
    drive(1, 1, 0, 0, 0, "sat_init");
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 0, "sat_lu");
    drive(1, 1, 0, 0, 0, "sat_idle");
    check("sat_stall_cnt", 32'(stall_cnt), SAT);
    drive(1, 1, 0, 1, 0, "mw_frz");
    drive(1, 1, 0, 1, 0, "mw_frz");
    @(posedge clk);
    #2 rst_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_stall_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 1500; i++) begin
      bit rn;
      rn = ($urandom % 100) != 0;
      if (m_halt && ($urandom % 6) == 0) rn = 0;
      drive(rn, ($urandom % 4) != 0, ($urandom % 5) == 0, $urandom % 2 == 1, ($urandom % 3) != 0, "rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
